// File: rtl/emisor_sensores.sv
// Sensor stimulus transmitter: expands accepted 2-bit codes into timed one-hot
// patterns on sensores, with a capture strobe and an all-zero gap after each.
module emisor_sensores #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] code_in,
  input  logic       code_valid,
  output logic       code_ready,
  output logic [3:0] sensores,
  output logic       enable_out,
  output logic       busy,
  output logic [1:0] cod_eco,
  output logic [3:0] count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] HOLD_PRE  = 4'(HOLD_CYCLES - 2);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

  state_t     state, state_next;
  logic [3:0] cyc_cnt, cyc_next;
  logic [1:0] cod_next;
  logic [3:0] count_next;
  logic [3:0] sensores_next;
  logic       enable_next;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    state_next  = state;
    cyc_next    = cyc_cnt;
    cod_next    = cod_eco;
    count_next  = count;
    enable_next = 1'b0;

    case (state)
      IDLE: begin
        if (code_valid) begin
          state_next = DRIVE;
          cyc_next   = 4'd0;
          cod_next   = code_in;
        end
      end
      DRIVE: begin
        if (cyc_cnt == HOLD_LAST) begin
          state_next = GAP;
          cyc_next   = 4'd0;
          count_next = count + 4'd1;
        end else begin
          cyc_next    = cyc_cnt + 4'd1;
          // Strobe is registered, so it is raised one edge early to land in the last DRIVE cycle.
          enable_next = (cyc_cnt == HOLD_PRE);
        end
      end
      GAP: begin
        if (cyc_cnt == GAP_LAST) begin
          state_next = IDLE;
          cyc_next   = 4'd0;
        end else begin
          cyc_next = cyc_cnt + 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cyc_next   = 4'd0;
      end
    endcase

    sensores_next = (state_next == DRIVE) ? (4'b0001 << cod_next) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (reset) begin
      state      <= IDLE;
      cyc_cnt    <= 4'd0;
      cod_eco    <= 2'b00;
      count      <= 4'h0;
      sensores   <= 4'b0000;
      enable_out <= 1'b0;
    end else begin
      state      <= state_next;
      cyc_cnt    <= cyc_next;
      cod_eco    <= cod_next;
      count      <= count_next;
      sensores   <= sensores_next;
      enable_out <= enable_next;
    end
  end

  assign code_ready = (state == IDLE);
  assign busy       = ~code_ready;

endmodule

// File: tb/tb_emisor_sensores.sv
// Directed bench for emisor_sensores: default timing instance plus a short
// HOLD=2/GAP=1 instance used for the count wrap.
module tb_emisor_sensores;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic       reset, code_valid, code_ready, enable_out, busy;
  logic [1:0] code_in, cod_eco;
  logic [3:0] sensores, count;

  // Instance B: HOLD_CYCLES=2, GAP_CYCLES=1
  logic       b_reset, b_valid, b_ready, b_enable, b_busy;
  logic [1:0] b_code, b_cod_eco;
  logic [3:0] b_sensores, b_count;

  emisor_sensores dut_a (
    .clk        (clk),
    .reset      (reset),
    .code_in    (code_in),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .sensores   (sensores),
    .enable_out (enable_out),
    .busy       (busy),
    .cod_eco    (cod_eco),
    .count      (count)
  );

  emisor_sensores #(.HOLD_CYCLES(2), .GAP_CYCLES(1)) dut_b (
    .clk        (clk),
    .reset      (b_reset),
    .code_in    (b_code),
    .code_valid (b_valid),
    .code_ready (b_ready),
    .sensores   (b_sensores),
    .enable_out (b_enable),
    .busy       (b_busy),
    .cod_eco    (b_cod_eco),
    .count      (b_count)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_ready_a();
    int guard = 0;
    while (!code_ready && guard < 20) begin
      step();
      guard++;
    end
    check("a_ready_wait", 32'(code_ready), 32'd1);
  endtask

  task automatic wait_ready_b();
    int guard = 0;
    while (!b_ready && guard < 20) begin
      step();
      guard++;
    end
    check("b_ready_wait", 32'(b_ready), 32'd1);
  endtask

  initial begin
    int acc, prev;
    reset = 1'b1; code_valid = 1'b0; code_in = 2'b00;
    b_reset = 1'b1; b_valid = 1'b0; b_code = 2'b00;

    // Reset then idle
    step(); step();
    check("rst_sensores", 32'(sensores), 32'h0);
    check("rst_ready",    32'(code_ready), 32'd1);
    check("rst_busy",     32'(busy), 32'd0);
    check("rst_count",    32'(count), 32'h0);
    check("rst_enable",   32'(enable_out), 32'd0);
    check("rst_cod_eco",  32'(cod_eco), 32'h0);
    reset = 1'b0; b_reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("idle_enable",   32'(enable_out), 32'd0);
      check("idle_sensores", 32'(sensores), 32'h0);
    end

    // Single code 2'b10 with defaults
    code_in = 2'b10; code_valid = 1'b1;
    step();
    code_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check("one_sensores", 32'(sensores), 32'h4);
      check("one_enable",   32'(enable_out), (k == 4) ? 32'd1 : 32'd0);
      check("one_busy",     32'(busy), 32'd1);
      check("one_count",    32'(count), 32'h0);
      step();
    end
    for (int k = 1; k <= 2; k++) begin
      check("one_gap_sensores", 32'(sensores), 32'h0);
      check("one_gap_enable",   32'(enable_out), 32'd0);
      check("one_gap_ready",    32'(code_ready), 32'd0);
      check("one_gap_count",    32'(count), 32'h1);
      step();
    end
    check("one_ready_back", 32'(code_ready), 32'd1);
    check("one_cod_eco",    32'(cod_eco), 32'h2);

    // Back-to-back stream with code_valid held high
    code_valid = 1'b1;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      code_in = 2'(i);
      wait_ready_a();
      acc = cyc;
      step();
      if (i > 0) check("bb_spacing", 32'(acc - prev), 32'd7);
      prev = acc;
      code_in = 2'(3 - i);
      for (int k = 1; k <= 4; k++) begin
        check("bb_sensores", 32'(sensores), 32'(1 << i));
        check("bb_enable",   32'(enable_out), (k == 4) ? 32'd1 : 32'd0);
        step();
      end
    end
    code_valid = 1'b0;
    wait_ready_a();
    check("bb_count",   32'(count), 32'h5);
    check("bb_cod_eco", 32'(cod_eco), 32'h3);

    // Input changes while busy are ignored
    code_in = 2'b01; code_valid = 1'b1;
    step();
    code_valid = 1'b0; code_in = 2'b11;
    for (int k = 1; k <= 4; k++) begin
      check("busy_sensores", 32'(sensores), 32'h2);
      check("busy_cod_eco",  32'(cod_eco), 32'h1);
      step();
    end
    wait_ready_a();
    check("busy_idle_cod_eco", 32'(cod_eco), 32'h1);
    check("busy_count",        32'(count), 32'h6);

    // Reset mid-DRIVE
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("pre_count_cleared", 32'(count), 32'h0);
    code_in = 2'b10; code_valid = 1'b1;
    step();
    code_valid = 1'b0;
    step();
    check("mid_drive_sensores", 32'(sensores), 32'h4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_sensores", 32'(sensores), 32'h0);
    check("mid_rst_ready",    32'(code_ready), 32'd1);
    check("mid_rst_enable",   32'(enable_out), 32'd0);
    check("mid_rst_count",    32'(count), 32'h0);
    for (int k = 0; k < 6; k++) begin
      step();
      check("mid_rst_no_strobe", 32'(enable_out), 32'd0);
    end
    check("mid_rst_count_after", 32'(count), 32'h0);

    // Reset wins over a simultaneous handshake
    reset = 1'b1; code_valid = 1'b1; code_in = 2'b11;
    step();
    reset = 1'b0; code_valid = 1'b0;
    check("rst_prio_busy",    32'(busy), 32'd0);
    check("rst_prio_cod_eco", 32'(cod_eco), 32'h0);
    step();
    check("rst_prio_sensores", 32'(sensores), 32'h0);

    // Counter wrap on the short-timing instance
    b_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      b_code = 2'(i % 4);
      wait_ready_b();
      step();
      check("wrap_sensores", 32'(b_sensores), 32'(1 << (i % 4)));
      check("wrap_enable_c1", 32'(b_enable), 32'd0);
      step();
      check("wrap_enable_c2", 32'(b_enable), 32'd1);
      check("wrap_count_pre", 32'(b_count), 32'(i % 16));
      step();
      check("wrap_enable_off", 32'(b_enable), 32'd0);
      check("wrap_count",      32'(b_count), 32'((i + 1) % 16));
    end
    b_valid = 1'b0;
    wait_ready_b();
    check("wrap_final_count", 32'(b_count), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/emisor_sensores.md
# emisor_sensores

Sensor-side stimulus transmitter for the accumulator datapath: it does the opposite job of the 4-to-2 sensor encoder. It accepts 2-bit codes over a valid/ready handshake and expands each one into a one-hot pattern on a 4-bit `sensores` bus. The pattern is held for a fixed number of cycles, and the block emits a one-cycle `enable_out` strobe so the accumulator register captures the summed value. Between codes it drives an all-zero gap, which lets downstream encoder/sumador/register logic run from a scripted code stream instead of physical switches.

## Interface
- `HOLD_CYCLES`, default 4: cycles each one-hot pattern is driven. Legal range 2..15.
- `GAP_CYCLES`, default 2: cycles of all-zero `sensores` after each pattern. Legal range 1..15.
- `clk` in, 1: single clock. All state changes on the rising edge.
- `reset` in, 1: synchronous, active-high reset.
- `code_in` in, 2: code to transmit. Sampled only on handshake.
- `code_valid` in, 1: the producer has a code on `code_in`.
- `code_ready` out, 1: the block can accept a code. High only in IDLE.
- `sensores` out, 4: one-hot sensor pattern. Connects to the encoder's sensor inputs.
- `enable_out` out, 1: one-cycle capture strobe for the accumulator register.
- `busy` out, 1: high in DRIVE or GAP.
- `cod_eco` out, 2: last accepted code. Held until the next accept.
- `count` out, 4: number of strobes issued, modulo 16.

## Operation
- FSM states:
  - IDLE: `sensores`=0, `code_ready`=1.
  - DRIVE: drive the decoded pattern.
  - GAP: `sensores`=0.
- Decode of the latched code:
  - 2'b11 → 4'b1000
  - 2'b10 → 4'b0100
  - 2'b01 → 4'b0010
  - 2'b00 → 4'b0001
- Exactly one `sensores` bit is high in DRIVE. All bits are low in IDLE and GAP.
- Accept: on an edge with `code_valid` && `code_ready`, latch `code_in` into `cod_eco` and go IDLE→DRIVE.
- While not in IDLE, `code_in` and `code_valid` are ignored and the latched code is used.
- DRIVE lasts exactly `HOLD_CYCLES` cycles (internal 4-bit cycle counter). Then DRIVE→GAP.
- `enable_out`=1 only in the last DRIVE cycle. `count` increments on the same edge that ends that cycle, wrapping 15→0.
- GAP lasts exactly `GAP_CYCLES` cycles. Then GAP→IDLE.
- `code_ready` and `busy` are decoded directly from the registered state. `code_ready` = !`busy`.
- `sensores`, `enable_out` and `count` are registered outputs, with no combinational path from inputs.
- Reset values:
  - state = IDLE
  - `sensores` = 4'b0000
  - `enable_out` = 0
  - `code_ready` = 1
  - `busy` = 0
  - `cod_eco` = 2'b00
  - `count` = 4'h0
  - internal cycle counter = 0
- Reset mid-DRIVE or mid-GAP: the code in flight is abandoned and no strobe is issued. Outputs take their reset values on the next edge.
- Reset has priority over a simultaneous handshake. A code presented in the same cycle as reset is not accepted.

## Timing
- Accept at edge E0. `sensores` shows the pattern from E0+1 through E0+`HOLD_CYCLES`.
- `enable_out` is high in the cycle after edge E0+`HOLD_CYCLES`−1.
- `sensores`=0 for `GAP_CYCLES` cycles. `code_ready` returns high in the cycle after edge E0+`HOLD_CYCLES`+`GAP_CYCLES`.
- Throughput: one code per `HOLD_CYCLES`+`GAP_CYCLES`+1 cycles when `code_valid` is held high. With the defaults, that is 7 cycles.
- Accept-to-strobe latency is `HOLD_CYCLES` cycles.
- The pattern has been stable for `HOLD_CYCLES`−1 cycles before the strobe, so the encoder and sumador outputs have settled when the register captures.
- `code_valid` may drop without penalty while `code_ready`=0. No code is lost or duplicated.

## Test plan
- Reset then idle: `reset`=1 for 2 cycles, `code_valid`=0 → `sensores`=0, `code_ready`=1, `count`=0, `enable_out` never asserted.
- Single code, defaults: `code_in`=2'b10 valid for 1 cycle → `sensores`=4'b0100 for exactly 4 cycles, `enable_out` pulse in the 4th, then 0 for 2 cycles, `count`=1, `cod_eco`=2'b10, `code_ready` high after 6 cycles.
- Back-to-back stream, `code_valid` held high: codes 00, 01, 10, 11 → `sensores` 0001, 0010, 0100, 1000 in order, accepts spaced exactly 7 cycles apart, 4 strobes, `count`=4.
- Input changes while busy: accept 2'b01, then set `code_in`=2'b11 during DRIVE → `sensores` stays 4'b0010 and `cod_eco` stays 01 until the next accept.
- Reset mid-DRIVE: assert `reset` at DRIVE cycle 2 → no `enable_out`, `count` unchanged at 0, `sensores`=0 next cycle, `code_ready`=1.
- Counter wrap with `HOLD_CYCLES`=2, `GAP_CYCLES`=1: send 17 codes → `count` goes 15→0→1, and each strobe is exactly 1 cycle wide.
